mem_access_unit: RTL and testbench

MEM-stage load/store engine, directly downstream of the MEM segment register. Consumes the latched ALU address, store data and memory control fields, and runs a req/gnt + rvalid handshake to the data cache/memory port. Holds the pipeline with stall_m while an access is outstanding. Delivers byte-aligned, sign/zero-extended load data to the WB segment register.

---
 rtl/mem_access_unit.sv | 197 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: drives a req/gnt + rvalid handshake towards the
// data memory and holds the pipeline (stall_m) while an access is in flight.
// Store data/enables are lane-shifted on issue. Load data is lane-shifted and
// then sign/zero-extended into LoadDataM.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] AluOutM,
    input  logic [31:0] StoreDataM,
    input  logic [3:0]  MemWriteM,
    input  logic        MemToRegM,
    input  logic [2:0]  RegWriteM,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        stall_m,
    output logic [31:0] LoadDataM,
    output logic        err_m
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_t;

    // Counter value seen during the last permitted REQ/WAIT cycle.
    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYC - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [31:0] addr_q, wdata_q, ld_q;
    logic [3:0]  we_q;
    logic [1:0]  off_q;
    logic [2:0]  ltype_q;
    logic        load_q;

    logic [1:0]  off;
    logic        is_load, access, misaligned;
    logic [3:0]  we_shift;
    logic [31:0] wdata_shift, rd_shift, ext_data;
    logic        latch_req, capture, last_cyc;

    // Decode the latched MEM-stage fields: access kind, lane shifts, alignment.
    always_comb begin
        off         = AluOutM[1:0];
        is_load     = MemToRegM;
        access      = MemToRegM | (|MemWriteM);
        we_shift    = is_load ? '0 : (MemWriteM << off);
        wdata_shift = StoreDataM << {off, 3'b000};
        misaligned  = 1'b0;
        if (is_load) begin
            case (RegWriteM)
                3'd3:       misaligned = (off != 2'b00);
                3'd2, 3'd5: misaligned = off[0];
                default:    misaligned = 1'b0;
            endcase
        end else begin
            case (MemWriteM)
                4'b1111: misaligned = (off != 2'b00);
                4'b0011: misaligned = off[0];
                default: misaligned = 1'b0;
            endcase
        end
    end

    // Align the returned word to lane 0 and extend according to the load type.
    always_comb begin
        rd_shift = mem_rdata >> {off_q, 3'b000};
        case (ltype_q)
            3'd1:    ext_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'd2:    ext_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'd4:    ext_data = {24'd0, rd_shift[7:0]};
            3'd5:    ext_data = {16'd0, rd_shift[15:0]};
            default: ext_data = rd_shift;
        endcase
    end

    // Next-state logic, timeout counting and error/capture decisions.
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        err_d     = 1'b0;
        capture   = 1'b0;
        latch_req = 1'b0;
        last_cyc  = (cnt_q == LAST_CNT);
        case (state_q)
            IDLE: begin
                if (access) begin
                    if (misaligned) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d   = REQ;
                        latch_req = 1'b1;
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_q + 8'd1;
                if (mem_gnt && !load_q) begin
                    state_d = DONE;
                end else if (mem_gnt && mem_rvalid) begin
                    state_d = DONE;
                    capture = 1'b1;
                end else if (last_cyc) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else if (mem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (mem_rvalid) begin
                    state_d = DONE;
                    capture = 1'b1;
                end else if (last_cyc) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (state_d != REQ && state_d != WAIT) begin
            cnt_d = '0;
        end
    end

    // Control state: FSM, timeout counter and the DONE-cycle error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Request fields are frozen at issue so they stay stable until gnt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            we_q    <= '0;
            wdata_q <= '0;
            off_q   <= '0;
            ltype_q <= '0;
            load_q  <= 1'b0;
        end else if (latch_req) begin
            addr_q  <= {AluOutM[31:2], 2'b00};
            we_q    <= we_shift;
            wdata_q <= wdata_shift;
            off_q   <= off;
            ltype_q <= RegWriteM;
            load_q  <= is_load;
        end
    end

    // Load result register: only a completed read updates it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_q <= '0;
        end else if (capture) begin
            ld_q <= ext_data;
        end
    end

    // Pipeline hold: in IDLE it follows the incoming access request directly.
    always_comb begin
        case (state_q)
            IDLE:      stall_m = access;
            REQ, WAIT: stall_m = 1'b1;
            default:   stall_m = 1'b0;
        endcase
    end

    assign mem_req   = (state_q == REQ);
    assign mem_we    = (state_q == REQ) ? we_q : '0;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign LoadDataM = ld_q;
    assign err_m     = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a directed vector table, timeout and reset
// sequences, then randomized accesses checked against a behavioural model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] AluOutM, StoreDataM, mem_rdata;
    logic [3:0]  MemWriteM;
    logic        MemToRegM;
    logic [2:0]  RegWriteM;
    logic        mem_gnt, mem_rvalid;
    logic        mem_req, stall_m, err_m;
    logic [31:0] mem_addr, mem_wdata, LoadDataM;
    logic [3:0]  mem_we;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_ld = '0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [3:0]  mask;
        logic        ld;
        logic [2:0]  lt;
        logic [31:0] rdata;
        int          g;
        int          r;
        logic        exp_err;
        logic [31:0] exp_addr;
        logic [3:0]  exp_we;
        logic [31:0] exp_wdata;
        logic [31:0] exp_ld;
        int          exp_done;
        int          exp_reqc;
    } vec_t;

    vec_t vecs[13];

    mem_access_unit #(.TIMEOUT_CYC(255)) dut (
        .clk       (clk),
        .rst       (rst),
        .AluOutM   (AluOutM),
        .StoreDataM(StoreDataM),
        .MemWriteM (MemWriteM),
        .MemToRegM (MemToRegM),
        .RegWriteM (RegWriteM),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_gnt   (mem_gnt),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata),
        .stall_m   (stall_m),
        .LoadDataM (LoadDataM),
        .err_m     (err_m)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_idle();
        AluOutM    = '0;
        StoreDataM = '0;
        MemWriteM  = '0;
        MemToRegM  = 1'b0;
        RegWriteM  = '0;
    endtask

    // Bytes per access: load size from the load type, store size from the mask.
    function automatic int unsigned acc_size(input logic ld, input logic [2:0] lt,
                                             input logic [3:0] mask);
        if (ld) begin
            if (lt == 3'd3) return 4;
            if (lt == 3'd2 || lt == 3'd5) return 2;
            return 1;
        end
        if (mask == 4'hF) return 4;
        if (mask == 4'h3) return 2;
        return 1;
    endfunction

    // Load result from the extension rules, using plain arithmetic.
    function automatic logic [31:0] ref_load(input logic [31:0] rd, input int unsigned off,
                                             input logic [2:0] lt);
        logic [31:0] w, b, h;
        w = rd >> (8 * off);
        b = w % 32'd256;
        h = w % 32'd65536;
        case (lt)
            3'd1:    return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
            3'd4:    return b;
            3'd2:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    // One access from IDLE to DONE, playing the memory side with gnt after g
    // extra REQ cycles and rvalid r cycles after gnt (0 = same cycle as gnt).
    task automatic run_access(input logic [31:0] addr, input logic [31:0] sdata,
                              input logic [3:0] mask, input logic ld, input logic [2:0] lt,
                              input logic [31:0] rdata, input int g, input int r,
                              input logic exp_err, input logic [31:0] exp_addr,
                              input logic [3:0] exp_we, input logic [31:0] exp_wdata,
                              input logic [31:0] exp_ld, input int exp_done, input int exp_reqc);
        int   cyc, reqc, waitc;
        logic done;
        @(negedge clk);
        chk("ld_hold", LoadDataM, model_ld);
        chk("err_clear", 32'(err_m), 32'd0);
        AluOutM    = addr;
        StoreDataM = sdata;
        MemWriteM  = mask;
        MemToRegM  = ld;
        RegWriteM  = lt;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        #1;
        chk("stall_idle", 32'(stall_m), 32'd1);
        chk("req_idle", 32'(mem_req), 32'd0);
        cyc   = 0;
        reqc  = 0;
        waitc = 0;
        done  = 1'b0;
        while (!done && cyc < 400) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom();
            if (mem_req) begin
                reqc++;
                chk("req_addr", mem_addr, exp_addr);
                chk("req_we", 32'(mem_we), 32'(exp_we));
                if (!ld) chk("req_wdata", mem_wdata, exp_wdata);
                chk("req_stall", 32'(stall_m), 32'd1);
                if (reqc == g + 1) begin
                    mem_gnt = 1'b1;
                    if (ld && r == 0) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = rdata;
                    end
                end else begin
                    mem_rvalid = 1'($urandom_range(0, 1));
                end
            end else if (stall_m) begin
                waitc++;
                if (waitc == r) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rdata;
                end
            end else begin
                done = 1'b1;
            end
        end
        chk("done_seen", 32'(done), 32'd1);
        chk("latency", cyc, exp_done);
        chk("err_pulse", 32'(err_m), 32'(exp_err));
        chk("req_cycles", reqc, exp_reqc);
        if (ld && !exp_err) model_ld = exp_ld;
        chk("load_data", LoadDataM, model_ld);
        set_idle();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = $urandom();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, sd, rd;
        logic [3:0]  m;
        logic        ld, mis;
        logic [2:0]  lt;
        int unsigned off, g, r, kind;

        vecs[0]  = '{addr:32'h1003, sdata:32'hAB, mask:4'b0001, ld:1'b0, lt:3'd0, rdata:32'h0, g:0, r:0,
                     exp_err:1'b0, exp_addr:32'h1000, exp_we:4'b1000, exp_wdata:32'hAB00_0000, exp_ld:32'h0, exp_done:2, exp_reqc:1};
        vecs[1]  = '{addr:32'h2001, sdata:32'h0, mask:4'b0000, ld:1'b1, lt:3'd1, rdata:32'h12F0_3456, g:0, r:1,
                     exp_err:1'b0, exp_addr:32'h2000, exp_we:4'b0000, exp_wdata:32'h0, exp_ld:32'h0000_0034, exp_done:3, exp_reqc:1};
        vecs[2]  = '{addr:32'h2001, sdata:32'h0, mask:4'b0000, ld:1'b1, lt:3'd1, rdata:32'h0000_8000, g:0, r:1,
                     exp_err:1'b0, exp_addr:32'h2000, exp_we:4'b0000, exp_wdata:32'h0, exp_ld:32'hFFFF_FF80, exp_done:3, exp_reqc:1};
        vecs[3]  = '{addr:32'h2002, sdata:32'h0, mask:4'b0000, ld:1'b1, lt:3'd5, rdata:32'h8001_0000, g:0, r:1,
                     exp_err:1'b0, exp_addr:32'h2000, exp_we:4'b0000, exp_wdata:32'h0, exp_ld:32'h0000_8001, exp_done:3, exp_reqc:1};
        vecs[4]  = '{addr:32'h2002, sdata:32'h0, mask:4'b0000, ld:1'b1, lt:3'd2, rdata:32'h8001_0000, g:0, r:1,
                     exp_err:1'b0, exp_addr:32'h2000, exp_we:4'b0000, exp_wdata:32'h0, exp_ld:32'hFFFF_8001, exp_done:3, exp_reqc:1};
        vecs[5]  = '{addr:32'h3002, sdata:32'h0, mask:4'b0000, ld:1'b1, lt:3'd3, rdata:32'h0, g:0, r:1,
                     exp_err:1'b1, exp_addr:32'h0, exp_we:4'b0000, exp_wdata:32'h0, exp_ld:32'h0, exp_done:1, exp_reqc:0};
        vecs[6]  = '{addr:32'h4000, sdata:32'hDEAD_BEEF, mask:4'b1111, ld:1'b0, lt:3'd0, rdata:32'h0, g:5, r:0,
                     exp_err:1'b0, exp_addr:32'h4000, exp_we:4'b1111, exp_wdata:32'hDEAD_BEEF, exp_ld:32'h0, exp_done:7, exp_reqc:6};
        vecs[7]  = '{addr:32'h5002, sdata:32'h1234, mask:4'b0011, ld:1'b0, lt:3'd0, rdata:32'h0, g:0, r:0,
                     exp_err:1'b0, exp_addr:32'h5000, exp_we:4'b1100, exp_wdata:32'h1234_0000, exp_ld:32'h0, exp_done:2, exp_reqc:1};
        vecs[8]  = '{addr:32'h6000, sdata:32'h0, mask:4'b0000, ld:1'b1, lt:3'd3, rdata:32'hCAFE_F00D, g:0, r:0,
                     exp_err:1'b0, exp_addr:32'h6000, exp_we:4'b0000, exp_wdata:32'h0, exp_ld:32'hCAFE_F00D, exp_done:2, exp_reqc:1};
        vecs[9]  = '{addr:32'h7003, sdata:32'h0, mask:4'b0000, ld:1'b1, lt:3'd4, rdata:32'h9A00_0000, g:1, r:2,
                     exp_err:1'b0, exp_addr:32'h7000, exp_we:4'b0000, exp_wdata:32'h0, exp_ld:32'h0000_009A, exp_done:5, exp_reqc:2};
        vecs[10] = '{addr:32'h5001, sdata:32'h55, mask:4'b0011, ld:1'b0, lt:3'd0, rdata:32'h0, g:0, r:0,
                     exp_err:1'b1, exp_addr:32'h0, exp_we:4'b0000, exp_wdata:32'h0, exp_ld:32'h0, exp_done:1, exp_reqc:0};
        vecs[11] = '{addr:32'h8000, sdata:32'hFFFF_FFFF, mask:4'b1111, ld:1'b1, lt:3'd3, rdata:32'h1122_3344, g:0, r:1,
                     exp_err:1'b0, exp_addr:32'h8000, exp_we:4'b0000, exp_wdata:32'h0, exp_ld:32'h1122_3344, exp_done:3, exp_reqc:1};
        vecs[12] = '{addr:32'h2000, sdata:32'h0, mask:4'b0000, ld:1'b1, lt:3'd2, rdata:32'h0000_7FFF, g:2, r:3,
                     exp_err:1'b0, exp_addr:32'h2000, exp_we:4'b0000, exp_wdata:32'h0, exp_ld:32'h0000_7FFF, exp_done:7, exp_reqc:3};

        set_idle();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        repeat (2) @(negedge clk);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_ld", LoadDataM, 32'd0);
        chk("rst_err", 32'(err_m), 32'd0);
        chk("rst_stall", 32'(stall_m), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run_access(vecs[i].addr, vecs[i].sdata, vecs[i].mask, vecs[i].ld, vecs[i].lt,
                       vecs[i].rdata, vecs[i].g, vecs[i].r, vecs[i].exp_err, vecs[i].exp_addr,
                       vecs[i].exp_we, vecs[i].exp_wdata, vecs[i].exp_ld, vecs[i].exp_done,
                       vecs[i].exp_reqc);
        end

        // Memory never grants a load: 255 REQ cycles, then DONE with err_m.
        run_access(32'h9000, 32'h0, 4'h0, 1'b1, 3'd3, 32'h0, 1000, 0,
                   1'b1, 32'h9000, 4'h0, 32'h0, 32'h0, 256, 255);
        // Load granted at once but data never returns: 1 REQ + 254 WAIT.
        run_access(32'h9104, 32'h0, 4'h0, 1'b1, 3'd1, 32'h0, 0, 1000,
                   1'b1, 32'h9104, 4'h0, 32'h0, 32'h0, 256, 1);
        // Store never granted.
        run_access(32'hA000, 32'h0BAD_F00D, 4'hF, 1'b0, 3'd0, 32'h0, 1000, 0,
                   1'b1, 32'hA000, 4'hF, 32'h0BAD_F00D, 32'h0, 256, 255);

        // Asynchronous reset in WAIT, then a late rvalid must be ignored.
        @(negedge clk);
        mem_rvalid = 1'b0;
        AluOutM    = 32'hB000;
        MemToRegM  = 1'b1;
        RegWriteM  = 3'd3;
        @(negedge clk);
        chk("rw_req", 32'(mem_req), 32'd1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("rw_wait_req", 32'(mem_req), 32'd0);
        chk("rw_wait_stall", 32'(stall_m), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rw_req_rst", 32'(mem_req), 32'd0);
        chk("rw_we_rst", 32'(mem_we), 32'd0);
        chk("rw_addr_rst", mem_addr, 32'd0);
        chk("rw_wdata_rst", mem_wdata, 32'd0);
        chk("rw_ld_rst", LoadDataM, 32'd0);
        chk("rw_err_rst", 32'(err_m), 32'd0);
        set_idle();
        @(negedge clk);
        rst        = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        chk("rw_late_rvalid", LoadDataM, 32'd0);
        chk("rw_idle_stall", 32'(stall_m), 32'd0);
        chk("rw_idle_req", 32'(mem_req), 32'd0);
        model_ld   = '0;
        mem_rvalid = 1'b0;

        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 3);
            if (kind == 3) begin
                @(negedge clk);
                set_idle();
                mem_rvalid = 1'b1;
                mem_rdata  = $urandom();
                #1;
                chk("idle_stall", 32'(stall_m), 32'd0);
                chk("idle_req", 32'(mem_req), 32'd0);
            end else begin
                off = $urandom_range(0, 3);
                a   = $urandom();
                a   = (a & 32'hFFFF_FFFC) | off;
                sd  = $urandom();
                rd  = $urandom();
                ld  = (kind != 1);
                lt  = 3'($urandom_range(1, 5));
                m   = 4'h0;
                if (kind != 0) begin
                    case ($urandom_range(0, 2))
                        0:       m = 4'h1;
                        1:       m = 4'h3;
                        default: m = 4'hF;
                    endcase
                end
                g   = $urandom_range(0, 3);
                r   = $urandom_range(0, 3);
                mis = (off % acc_size(ld, lt, m)) != 0;
                run_access(a, sd, m, ld, lt, rd, int'(g), int'(r), mis,
                           a & 32'hFFFF_FFFC,
                           ld ? 4'h0 : 4'((m << off) & 4'hF),
                           sd << (8 * off),
                           ref_load(rd, off, lt),
                           mis ? 1 : (ld ? int'(g + r) + 2 : int'(g) + 2),
                           mis ? 0 : int'(g) + 1);
            end
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
